branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch comparator: resolves conditional branches and jumps in EX and keeps a PC-indexed branch history table (BHT) of 2-bit saturating counters.
- Fetch reads the BHT with 1-cycle latency. EX resolution is registered and reports taken, mispredict and redirect PC to the hazard/fetch logic.

Parameters:
XLEN, 32, data/PC width (>= 8)
BHT_DEPTH, 64, BHT entries; power of two, >= 2; IDX_W = log2(BHT_DEPTH)
CNT_INIT, 2'b01, counter value written during init (weakly not-taken)
PERF_W, 32, width of mispredict performance counter

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  synchronous active-high reset
o_ready  out  1  high once BHT init sweep is complete
i_pred_valid  in  1  fetch lookup request
i_pred_pc  in  XLEN  fetch PC
o_pred_taken  out  1  prediction for PC of previous cycle's request
i_res_valid  in  1  EX instruction valid
i_res_pc  in  XLEN  PC of EX instruction
i_dat_a  in  XLEN  rs1 value
i_dat_b  in  XLEN  rs2 value
i_funct3  in  3  funct3
i_opcode  in  5  opcode[6:2]
i_res_pred  in  1  prediction carried with the instruction from fetch
i_target  in  XLEN  computed branch/jump target
o_res_valid  out  1  registered i_res_valid
o_branch_en  out  1  actual taken outcome
o_mispredict  out  1  outcome differs from i_res_pred
o_redirect_pc  out  XLEN  correct next PC when o_mispredict
o_mispred_cnt  out  PERF_W  count of mispredicts since reset

Behaviour:
- Reset: all outputs 0, FSM to INIT, init index 0, o_mispred_cnt 0. Reset mid-operation aborts everything and restarts INIT.
- FSM INIT:
  - Writes CNT_INIT to entry idx each cycle; idx increments.
  - After writing entry BHT_DEPTH-1, moves to RUN the next cycle. INIT lasts exactly BHT_DEPTH cycles; o_ready=1 from the first RUN cycle.
  - Lookups return o_pred_taken=0 and resolutions do not update the BHT, but resolution outputs are still produced.
- FSM RUN: no exit except i_rst.
- Index: pc[IDX_W+1:2] for both lookup and update.
- Lookup: o_pred_taken <= i_pred_valid & o_ready & BHT[idx][1]. Registered, latency 1, 0 when no request.
- Decode:
  - jump = opcode 11011 or 11001.
  - branch = opcode 11000.
  - Conditions by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. funct3 010/011 give condition 0.
  - taken = jump | (branch & cond). All other opcodes: taken=0.
- Resolution, latency 1, all registered, valid only when i_res_valid:
  - o_branch_en = taken.
  - o_mispredict = taken != i_res_pred.
  - o_redirect_pc = taken ? i_target : i_res_pc + 4, modulo 2^XLEN.
  - When i_res_valid=0: o_res_valid, o_branch_en and o_mispredict are 0, and o_redirect_pc holds its previous value.
- BHT update: in RUN, for i_res_valid & branch only (never jumps or non-branches).
  - Counter +1 if taken, -1 if not.
  - Saturates at 2'b11 and 2'b00.
- Same-cycle lookup and update to the same index: lookup returns the pre-update value (read-before-write).
- o_mispred_cnt increments by 1 on each cycle where o_mispredict is set. Wraps at 2^PERF_W, no saturation.
- Non-branch opcodes with i_res_pred=1 are reported as mispredict with redirect to pc+4.

Test Plan:
- Reset then idle, BHT_DEPTH=64 -> o_ready low cycles 0..63 after reset release, high at cycle 64; lookup during INIT -> o_pred_taken=0.
- BEQ, a=b=0x5, pred=0, pc=0x100, target=0x200 -> next cycle o_branch_en=1, o_mispredict=1, o_redirect_pc=0x200, o_mispred_cnt=1; lookup of 0x100 afterwards -> o_pred_taken=1 (counter 01->10).
- BLT a=0xFFFFFFFF, b=1 -> taken; BLTU with the same operands -> not taken, redirect 0x104 when pred=1 at pc 0x100.
- Four taken BNE at pc 0x40, then one not-taken -> counter 01->10->11->11->11->10; lookup still predicts taken.
- JAL pred=0 -> mispredict, redirect=i_target, BHT entry unchanged. funct3=010 branch -> not taken.
- Lookup and update of pc 0x80 in the same cycle (counter 01, taken) -> o_pred_taken=0 that cycle, 1 on the next lookup. i_rst asserted mid-run -> counters back to CNT_INIT and o_mispred_cnt=0 after a full INIT sweep.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch lookup and EX resolution bundle for the branch predict unit
interface branch_predict_unit_if #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
);
  logic              o_ready;
  logic              i_pred_valid;
  logic [XLEN-1:0]   i_pred_pc;
  logic              o_pred_taken;
  logic              i_res_valid;
  logic [XLEN-1:0]   i_res_pc;
  logic [XLEN-1:0]   i_dat_a;
  logic [XLEN-1:0]   i_dat_b;
  logic [2:0]        i_funct3;
  logic [4:0]        i_opcode;
  logic              i_res_pred;
  logic [XLEN-1:0]   i_target;
  logic              o_res_valid;
  logic              o_branch_en;
  logic              o_mispredict;
  logic [XLEN-1:0]   o_redirect_pc;
  logic [PERF_W-1:0] o_mispred_cnt;

  modport master (
    output i_pred_valid, i_pred_pc, i_res_valid, i_res_pc, i_dat_a, i_dat_b,
           i_funct3, i_opcode, i_res_pred, i_target,
    input  o_ready, o_pred_taken, o_res_valid, o_branch_en, o_mispredict,
           o_redirect_pc, o_mispred_cnt
  );

  modport slave (
    input  i_pred_valid, i_pred_pc, i_res_valid, i_res_pc, i_dat_a, i_dat_b,
           i_funct3, i_opcode, i_res_pred, i_target,
    output o_ready, o_pred_taken, o_res_valid, o_branch_en, o_mispredict,
           o_redirect_pc, o_mispred_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - EX branch resolution with a PC-indexed 2-bit counter history table
module branch_predict_unit #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CNT_INIT  = 2'b01,
  parameter int         PERF_W    = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  branch_predict_unit_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] init_idx;
  logic             ready, init_we;
  logic [1:0]       bht [BHT_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_INIT;
      init_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) init_idx <= init_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && init_idx == IDX_W'(BHT_DEPTH - 1)) state_nxt = S_RUN;
  end

  always_comb begin
    ready   = (state == S_RUN);
    init_we = (state == S_INIT);
  end

  assign bus.o_ready = ready;

  logic             is_jump, is_branch, cond, taken, mispred;
  logic [XLEN-1:0]  next_pc;
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [1:0]       cur_cnt, upd_cnt;

  always_comb begin
    is_jump   = (bus.i_opcode == 5'b11011) || (bus.i_opcode == 5'b11001);
    is_branch = (bus.i_opcode == 5'b11000);
    cond      = 1'b0;
    case (bus.i_funct3)
      3'b000:  cond = (bus.i_dat_a == bus.i_dat_b);
      3'b001:  cond = (bus.i_dat_a != bus.i_dat_b);
      3'b100:  cond = ($signed(bus.i_dat_a) <  $signed(bus.i_dat_b));
      3'b101:  cond = ($signed(bus.i_dat_a) >= $signed(bus.i_dat_b));
      3'b110:  cond = (bus.i_dat_a <  bus.i_dat_b);
      3'b111:  cond = (bus.i_dat_a >= bus.i_dat_b);
      default: cond = 1'b0;
    endcase
    taken   = is_jump || (is_branch && cond);
    mispred = (taken != bus.i_res_pred);
    next_pc = taken ? bus.i_target : bus.i_res_pc + XLEN'(4);
  end

  // Saturating counter step for the resolved branch's entry.
  always_comb begin
    lk_idx  = bus.i_pred_pc[IDX_W+1:2];
    up_idx  = bus.i_res_pc[IDX_W+1:2];
    cur_cnt = bht[up_idx];
    upd_cnt = cur_cnt;
    if (taken && cur_cnt != 2'b11)       upd_cnt = cur_cnt + 2'b01;
    else if (!taken && cur_cnt != 2'b00) upd_cnt = cur_cnt - 2'b01;
  end

  // Table has no reset of its own; the INIT sweep establishes every entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (init_we)                                bht[init_idx] <= CNT_INIT;
      else if (bus.i_res_valid && is_branch)      bht[up_idx]   <= upd_cnt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_pred_taken  <= 1'b0;
      bus.o_res_valid   <= 1'b0;
      bus.o_branch_en   <= 1'b0;
      bus.o_mispredict  <= 1'b0;
      bus.o_redirect_pc <= '0;
      bus.o_mispred_cnt <= '0;
    end else begin
      bus.o_pred_taken  <= bus.i_pred_valid && ready && bht[lk_idx][1];
      bus.o_res_valid   <= bus.i_res_valid;
      bus.o_branch_en   <= bus.i_res_valid && taken;
      bus.o_mispredict  <= bus.i_res_valid && mispred;
      if (bus.i_res_valid) bus.o_redirect_pc <= next_pc;
      bus.o_mispred_cnt <= bus.o_mispred_cnt + PERF_W'(bus.i_res_valid && mispred);
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^bus.i_pred_pc;
endmodule
